// File: rtl/fp_pkg.sv
// Shared definitions for the float-to-integer decoder: FSM states, flag bit
// positions and the exponent bias helper.
package fp;

  typedef enum logic [1:0] {
    IDLE,
    CLASSIFY,
    SHIFT,
    DONE
  } state_e;

  // OUT_FLAGS = {INVALID, OVF, INEXACT}
  localparam int FLAG_INVALID = 2;
  localparam int FLAG_OVF     = 1;
  localparam int FLAG_INEXACT = 0;

  function automatic int EXP_OFFSET(input int nx);
    return (1 << (nx - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational field classification of an IEEE754 word: special cases plus
// the unbiased exponent as a signed NX+1 bit value.
module fp_classify
  import fp::*;
#(
  parameter int NX = 8,
  parameter int NM = 23
) (
  input  logic [NX-1:0]        exp_i,
  input  logic [NM-1:0]        mant_i,
  output logic                 is_zero,
  output logic                 is_denorm,
  output logic                 is_inf,
  output logic                 is_nan,
  output logic signed [NX:0]   e
);

  logic exp_ones, exp_zero, mant_zero;

  always_comb begin
    exp_ones  = &exp_i;
    exp_zero  = ~|exp_i;
    mant_zero = ~|mant_i;
    is_zero   = exp_zero & mant_zero;
    is_denorm = exp_zero & ~mant_zero;
    is_inf    = exp_ones & mant_zero;
    is_nan    = exp_ones & ~mant_zero;
    e = signed'({1'b0, exp_i}) - signed'((NX+1)'(EXP_OFFSET(NX)));
  end

endmodule

// File: rtl/fp_to_int_decode.sv
// Multi-cycle IEEE754 to two's-complement integer converter, truncating toward
// zero; the significand is aligned by a one-bit-per-cycle shifter.
module fp_to_int_decode
  import fp::*;
#(
  parameter int NX = 8,
  parameter int NM = 23,
  parameter int IW = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NX+NM:0]    IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic [IW-1:0]     OUT_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [2:0]        OUT_FLAGS
);

  localparam int SW   = (IW > NM + 1) ? IW : NM + 1;
  localparam int KMAX = (NM > IW - 2 - NM) ? NM : IW - 2 - NM;
  localparam int KW   = (KMAX < 1) ? 1 : $clog2(KMAX + 1);

  localparam logic [IW-1:0] INT_MAX = {1'b0, {(IW-1){1'b1}}};
  localparam logic [IW-1:0] INT_MIN = {1'b1, {(IW-1){1'b0}}};

  typedef struct packed {
    logic          sign;
    logic [NX-1:0] exp;
    logic [NM-1:0] mant;
  } ieee754_t;

  state_e         state_q, state_d;
  ieee754_t       word_q, word_d;
  logic [SW-1:0]  sh_q, sh_d, sh_next;
  logic [KW-1:0]  k_q, k_d;
  logic           left_q, left_d;
  logic           inexact_q, inexact_d;
  logic [IW-1:0]  out_data_q, out_data_d;
  logic [2:0]     out_flags_q, out_flags_d;

  logic              is_zero, is_denorm, is_inf, is_nan;
  logic signed [NX:0] e;
  int                e_int, k_int;

  fp_classify #(.NX(NX), .NM(NM)) u_classify (
    .exp_i     (word_q.exp),
    .mant_i    (word_q.mant),
    .is_zero   (is_zero),
    .is_denorm (is_denorm),
    .is_inf    (is_inf),
    .is_nan    (is_nan),
    .e         (e)
  );

  function automatic logic [IW-1:0] to_int(input logic neg, input logic [SW-1:0] mag);
    logic [IW-1:0] m;
    m = mag[IW-1:0];
    return neg ? (~m + 1'b1) : m;
  endfunction

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    sh_d        = sh_q;
    k_d         = k_q;
    left_d      = left_q;
    inexact_d   = inexact_q;
    out_data_d  = out_data_q;
    out_flags_d = out_flags_q;
    sh_next     = sh_q;
    e_int       = int'(e);
    k_int       = 0;
    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          word_d  = IN_DATA;
          state_d = CLASSIFY;
        end
      end
      CLASSIFY: begin
        out_flags_d = '0;
        inexact_d   = 1'b0;
        state_d     = DONE;
        if (is_nan) begin
          out_data_d                = INT_MAX;
          out_flags_d[FLAG_INVALID] = 1'b1;
        end else if (is_inf) begin
          out_data_d                = word_q.sign ? INT_MIN : INT_MAX;
          out_flags_d[FLAG_INVALID] = 1'b1;
        end else if (is_zero || is_denorm) begin
          out_data_d                = '0;
          out_flags_d[FLAG_INEXACT] = is_denorm;
        end else if (e_int < 0) begin
          out_data_d                = '0;
          out_flags_d[FLAG_INEXACT] = 1'b1;
        end else if (e_int >= IW - 1) begin
          // -2^(IW-1) itself is representable, so it alone escapes OVF
          out_data_d            = word_q.sign ? INT_MIN : INT_MAX;
          out_flags_d[FLAG_OVF] = !(word_q.sign && e_int == IW - 1 && word_q.mant == '0);
        end else begin
          sh_d   = SW'({1'b1, word_q.mant});
          left_d = e_int > NM;
          k_int  = left_d ? e_int - NM : NM - e_int;
          k_d    = KW'(k_int);
          if (k_int != 0) state_d = SHIFT;
          else            out_data_d = to_int(word_q.sign, sh_d);
        end
      end
      SHIFT: begin
        if (left_q) begin
          sh_next = sh_q << 1;
        end else begin
          sh_next   = sh_q >> 1;
          inexact_d = inexact_q | sh_q[0];
        end
        sh_d = sh_next;
        k_d  = k_q - 1'b1;
        if (k_q == KW'(1)) begin
          state_d                   = DONE;
          out_data_d                = to_int(word_q.sign, sh_next);
          out_flags_d               = '0;
          out_flags_d[FLAG_INEXACT] = inexact_d;
        end
      end
      DONE: begin
        if (OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      word_q      <= '0;
      sh_q        <= '0;
      k_q         <= '0;
      left_q      <= 1'b0;
      inexact_q   <= 1'b0;
      out_data_q  <= '0;
      out_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      sh_q        <= sh_d;
      k_q         <= k_d;
      left_q      <= left_d;
      inexact_q   <= inexact_d;
      out_data_q  <= out_data_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign IN_READY  = (state_q == IDLE);
  assign OUT_VALID = (state_q == DONE);
  assign OUT_DATA  = out_data_q;
  assign OUT_FLAGS = out_flags_q;

endmodule

// File: doc/fp_to_int_decode.md
FP_TO_INT_DECODE -- requirements
Module: fp_to_int_decode

Interface
REQ-001 SHALL have parameter NX, default 8, meaning exponent field width.
REQ-002 SHALL have parameter NM, default 23, meaning mantissa field width.
REQ-003 SHALL have parameter IW, default 32, meaning two's-complement result width.
REQ-004 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port RST_N, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port IN_DATA, input, 1+NX+NM, packed IEEE754 word (sign, exp, mant).
REQ-007 SHALL have port IN_VALID, input, 1, meaning IN_DATA is offered.
REQ-008 SHALL have port IN_READY, output, 1, meaning the block accepts IN_DATA this cycle.
REQ-009 SHALL have port OUT_DATA, output, IW, signed integer result.
REQ-010 SHALL have port OUT_VALID, output, 1, meaning the result and flags are valid.
REQ-011 SHALL have port OUT_READY, input, 1, meaning the consumer takes the result.
REQ-012 SHALL have port OUT_FLAGS, output, 3, {INVALID, OVF, INEXACT}.

Function
REQ-013 SHALL implement FSM states IDLE, CLASSIFY, SHIFT, DONE.
REQ-014 SHALL drive IN_READY=1 only in IDLE; a transfer is IN_VALID&IN_READY in cycle T; the word is registered; CLASSIFY in T+1.
REQ-015 SHALL compute e = exp - EXP_OFFSET(NX) in CLASSIFY, with signed width NX+1.
REQ-016 SHALL treat exp==all-ones as special: Inf gives saturation by sign; NaN gives 2^(IW-1)-1; INVALID=1; next state DONE.
REQ-017 SHALL treat exp==0 (zero or denormal) as result 0; INEXACT=1 iff mant!=0; next state DONE.
REQ-018 SHALL treat e<0 as result 0, INEXACT=1; next state DONE.
REQ-019 SHALL treat e>=IW-1 as overflow: saturate to 2^(IW-1)-1 (positive) or -2^(IW-1) (negative) with OVF=1, except sign=1, e==IW-1, mant==0, which gives exact -2^(IW-1) with no flags.
REQ-020 SHALL otherwise load significand {1,mant} into a max(IW,NM+1)-bit shifter with k=|e-NM| and go to SHIFT if k>0, else DONE.
REQ-021 SHALL shift one bit per SHIFT cycle (left if e>NM, right if e<NM) and decrement k, entering DONE when k reaches 0.
REQ-022 SHALL OR every bit shifted out to the right into INEXACT, giving truncation toward zero.
REQ-023 SHALL apply two's-complement negation when sign=1 on the transition into DONE.
REQ-024 SHALL assert OUT_VALID in cycle T+2+k for normal inputs and T+2 for special, zero and overflow inputs; maximum latency is 2+max(NM, IW-2-NM).
REQ-025 SHALL hold OUT_DATA, OUT_FLAGS and OUT_VALID stable in DONE until OUT_READY=1, then go to IDLE the next cycle.
REQ-026 SHALL ignore IN_VALID outside IDLE, with no overlap of operations.

Reset
REQ-027 SHALL, on RST_N=0 at a rising edge, enter IDLE with OUT_VALID=0, OUT_DATA=0, OUT_FLAGS=0 and k=0; IN_READY=1 after release.
REQ-028 SHALL abort an in-flight operation (CLASSIFY/SHIFT/DONE) on reset, with no result ever presented.

Structure
REQ-029 SHALL place the FSM state enum, the flag bit indices and the reuse of EXP_OFFSET in package fp.
REQ-030 SHALL use the IEEE754(NX, NM) packed struct to view IN_DATA.
REQ-031 SHALL isolate field classification (zero, denormal, inf, nan, e) in one combinational sub-module fp_classify.

Verification
REQ-032 Bench SHALL cover: 0x3F800000 (1.0) -> OUT_DATA=1, flags 000, OUT_VALID at T+25.
REQ-033 Bench SHALL cover: 0x40200000 (2.5) -> 2, INEXACT; 0xC0400000 (-3.0) -> 0xFFFFFFFD, flags 000; 0x4B800001 -> 0x01000002 at T+3.
REQ-034 Bench SHALL cover: 0x4F000000 -> 0x7FFFFFFF, OVF; 0xCF000000 -> 0x80000000, flags 000; 0x3E800000 -> 0, INEXACT at T+2.
REQ-035 Bench SHALL cover: 0x7FC00000 (NaN) -> 0x7FFFFFFF, INVALID; 0xFF800000 (-Inf) -> 0x80000000, INVALID.
REQ-036 Bench SHALL cover: OUT_READY held low 10 cycles in DONE -> outputs stable and IN_READY=0 throughout; IN_READY=1 one cycle after OUT_READY.
REQ-037 Bench SHALL cover: RST_N low for one cycle mid-SHIFT of 1.0 -> OUT_VALID never asserted for it; the next input 2.5 -> 2.
